// File: rtl/lc3_microsequencer_pkg.sv
// Shared constants for the LC-3 microsequencer: branch-condition codes and the fetch entry state.
package lc3_microsequencer_pkg;

    localparam logic [2:0] COND_UNCOND = 3'b000;
    localparam logic [2:0] COND_MEMR   = 3'b001;
    localparam logic [2:0] COND_BEN    = 3'b010;
    localparam logic [2:0] COND_ADDR   = 3'b011;
    localparam logic [2:0] COND_PRIV   = 3'b100;
    localparam logic [2:0] COND_INT    = 3'b101;

    localparam int unsigned STATE_FETCH = 18;

endpackage

// File: rtl/lc3_useq_next.sv
// Combinational next-microstate function: decode dispatch or j with one condition bit ORed in.
module lc3_useq_next
    import lc3_microsequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  ird,
    input  logic [2:0]            cond,
    input  logic [ADDR_WIDTH-1:0] j,
    input  logic [3:0]            ir_op,
    input  logic                  ir_11,
    input  logic                  ben,
    input  logic                  mem_r,
    input  logic                  psr_15,
    input  logic                  int_req,
    output logic [ADDR_WIDTH-1:0] next,
    output logic                  reserved
);

    always_comb begin
        next     = j;
        reserved = 1'b0;
        if (ird) begin
            next = {{(ADDR_WIDTH - 4){1'b0}}, ir_op};
        end else begin
            // Each condition forces a single bit high; no carry into neighbouring bits.
            case (cond)
                COND_UNCOND: next = j;
                COND_MEMR:   next[1] = j[1] | mem_r;
                COND_BEN:    next[2] = j[2] | ben;
                COND_ADDR:   next[0] = j[0] | ir_11;
                COND_PRIV:   next[3] = j[3] | psr_15;
                COND_INT:    next[4] = j[4] | int_req;
                default:     reserved = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer top: microstate register, stall/reset handling, sticky cond_err.
// Optional wait-cycle counter enabled by defining USEQ_WAIT_CNT_EN.
module lc3_microsequencer
    import lc3_microsequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned RESET_STATE = STATE_FETCH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  ird,
    input  logic [2:0]            cond,
    input  logic [ADDR_WIDTH-1:0] j,
    input  logic [3:0]            ir_op,
    input  logic                  ir_11,
    input  logic                  ben,
    input  logic                  mem_r,
    input  logic                  psr_15,
    input  logic                  int_req,
`ifdef USEQ_WAIT_CNT_EN
    output logic [15:0]           wait_cnt,
`endif
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  cond_err
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cond_err_q, cond_err_d;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  reserved;

    lc3_useq_next #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next (
        .ird     (ird),
        .cond    (cond),
        .j       (j),
        .ir_op   (ir_op),
        .ir_11   (ir_11),
        .ben     (ben),
        .mem_r   (mem_r),
        .psr_15  (psr_15),
        .int_req (int_req),
        .next    (next_addr),
        .reserved(reserved)
    );

    always_comb begin
        addr_d     = addr_q;
        cond_err_d = cond_err_q;
        if (!stall) begin
            addr_d     = next_addr;
            cond_err_d = cond_err_q | reserved;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= ADDR_WIDTH'(RESET_STATE);
            cond_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            cond_err_q <= cond_err_d;
        end
    end

    assign addr     = addr_q;
    assign cond_err = cond_err_q;

`ifdef USEQ_WAIT_CNT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        wait_cycle;

    assign wait_cycle = !stall && !ird && (cond == COND_MEMR) && !mem_r;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_cycle && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Self-checking bench for lc3_microsequencer: directed scenarios plus randomized run vs a model.
// Also checks wait_cnt when built with USEQ_WAIT_CNT_EN.
module tb_lc3_microsequencer;

    logic       clk = 1'b0;
    logic       rst, stall, ird, ir_11, ben, mem_r, psr_15, int_req;
    logic [2:0] cond;
    logic [5:0] j;
    logic [3:0] ir_op;
    logic [5:0] addr;
    logic       cond_err;
`ifdef USEQ_WAIT_CNT_EN
    logic [15:0] wait_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state
    int exp_addr;
    int exp_err;
    int exp_wait;

    always #5 clk = ~clk;

    lc3_microsequencer dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .ird     (ird),
        .cond    (cond),
        .j       (j),
        .ir_op   (ir_op),
        .ir_11   (ir_11),
        .ben     (ben),
        .mem_r   (mem_r),
        .psr_15  (psr_15),
        .int_req (int_req),
`ifdef USEQ_WAIT_CNT_EN
        .wait_cnt(wait_cnt),
`endif
        .addr    (addr),
        .cond_err(cond_err)
    );

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Next state from the rules: opcode dispatch, or j plus one selected condition bit.
    function automatic int model_next();
        int pos[8];
        int flag[8];
        pos  = '{-1, 1, 2, 0, 3, 4, -1, -1};
        flag = '{0, int'(mem_r), int'(ben), int'(ir_11), int'(psr_15), int'(int_req), 0, 0};
        if (ird) return int'(ir_op);
        if (pos[cond] >= 0 && flag[cond] != 0) return int'(j) | (1 << pos[cond]);
        return int'(j);
    endfunction

    // Advance the model with current inputs, clock once, compare outputs after the edge.
    task automatic tick(input string tag);
        if (rst) begin
            exp_addr = 18;
            exp_err  = 0;
            exp_wait = 0;
        end else if (!stall) begin
            if (!ird && cond >= 3'd6) exp_err = 1;
            if (!ird && cond == 3'd1 && !mem_r && exp_wait < 65535) exp_wait++;
            exp_addr = model_next();
        end
        @(posedge clk);
        #1;
        check({tag, ".addr"}, int'(addr), exp_addr);
        check({tag, ".cond_err"}, int'(cond_err), exp_err);
`ifdef USEQ_WAIT_CNT_EN
        check({tag, ".wait_cnt"}, int'(wait_cnt), exp_wait);
`endif
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; ird = 0; cond = 3'd0; j = 6'd0; ir_op = 4'd0;
        ir_11 = 0; ben = 0; mem_r = 0; psr_15 = 0; int_req = 0;
    endtask

    initial begin
        int held;
        logic [2:0] cset[4];
        int expect_hi[4];
        cset      = '{3'd2, 3'd3, 3'd4, 3'd5};
        expect_hi = '{4, 1, 8, 16};
        idle_inputs();
        exp_addr = 0; exp_err = 0; exp_wait = 0;

        // 1. Reset, and reset overriding stall
        rst = 1; cond = 3'd6; j = 6'd33;
        tick("reset");
        check("reset.addr18", int'(addr), 18);
        check("reset.err0", int'(cond_err), 0);
        rst = 0; cond = 3'd0; j = 6'd7;
        tick("leave_reset");
        rst = 1; stall = 1;
        tick("reset_stall");
        check("reset_stall.addr18", int'(addr), 18);
        rst = 0; stall = 0;

        // 2. Decode dispatch ignores j and cond
        ird = 1; ir_op = 4'b0101; j = 6'd63; cond = 3'd7;
        tick("ird");
        check("ird.addr5", int'(addr), 5);
        check("ird.no_err", int'(cond_err), 0);
        ird = 0;

        // 3. Memory wait loop
        rst = 1; tick("pre_wait_rst"); rst = 0;
        cond = 3'd1; j = 6'd28; mem_r = 0;
        for (int i = 0; i < 3; i++) begin
            tick("mem_wait");
            check("mem_wait.addr28", int'(addr), 28);
        end
        mem_r = 1;
        tick("mem_ready");
        check("mem_ready.addr30", int'(addr), 30);
`ifdef USEQ_WAIT_CNT_EN
        check("mem_ready.wait3", int'(wait_cnt), 3);
`endif
        mem_r = 0;

        // 4. Each condition bit, set and clear, with j=0
        j = 6'd0;
        for (int k = 0; k < 4; k++) begin
            cond = cset[k];
            {ben, ir_11, psr_15, int_req} = 4'b1111;
            tick("cond_hi");
            check("cond_hi.addr", int'(addr), expect_hi[k]);
            {ben, ir_11, psr_15, int_req} = 4'b0000;
            tick("cond_lo");
            check("cond_lo.addr0", int'(addr), 0);
        end

        // OR never carries: j=63 stays 63 under any condition
        j = 6'd63; cond = 3'd4; psr_15 = 1;
        tick("no_carry");
        check("no_carry.addr63", int'(addr), 63);
        psr_15 = 0;

        // 5. Stall holds regardless of inputs; stall beats mem_r
        cond = 3'd0; j = 6'd21;
        tick("pre_stall");
        held = int'(addr);
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            ird = 1'($urandom); cond = 3'($urandom); j = 6'($urandom);
            ir_op = 4'($urandom); mem_r = 1;
            tick("stall");
            check("stall.hold", int'(addr), held);
        end
        stall = 0; ird = 0; cond = 3'd1; j = 6'd12; mem_r = 1;
        tick("unstall");
        check("unstall.addr14", int'(addr), 14);
        mem_r = 0;

        // 6. Reserved cond is sticky until reset
        cond = 3'd6; j = 6'd9;
        tick("reserved");
        check("reserved.addr9", int'(addr), 9);
        check("reserved.err1", int'(cond_err), 1);
        cond = 3'd0; j = 6'd3;
        tick("sticky");
        check("sticky.err1", int'(cond_err), 1);
        rst = 1;
        tick("clear_err");
        check("clear_err.err0", int'(cond_err), 0);
        rst = 0;

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            ird     = ($urandom_range(0, 5) == 0);
            cond    = 3'($urandom_range(0, 15) == 0 ? $urandom_range(6, 7)
                                                    : $urandom_range(0, 5));
            j       = 6'($urandom);
            ir_op   = 4'($urandom);
            ir_11   = 1'($urandom);
            ben     = 1'($urandom);
            mem_r   = 1'($urandom);
            psr_15  = 1'($urandom);
            int_req = 1'($urandom);
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
